// File: rtl/axis_y_packer.sv
// Purpose : narrows ROWS-word column beats and gathers R of them into one AXI-Stream word; flushes partial words on packet end.
// Latency : a word-completing beat appears on m_tvalid one cycle after it is accepted.
// Backpres: s_ready = !m_tvalid || m_tready; the output register holds while m_tvalid && !m_tready.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data       input beats, ROWS words of Y_BITS, row 0 in the LSBs
//   s_last                       end of tile, ORed into m_tuser of the word it lands in
//   s_last_pkt                   last beat of a packet (flushes a partial word)
//   s_bytes_per_transfer         expected packet size, sampled on a packet's first beat
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast/m_tuser   AXI-Stream output
//   err_bpt                      sticky packet-size mismatch
//   pkt_count                    completed packets, wrapping
// Build option: define Y_SATURATE_EN to saturate (signed) instead of truncating when narrowing.
module axis_y_packer #(
    parameter int ROWS       = 8,
    parameter int Y_BITS     = 32,
    parameter int Y_OUT_BITS = 8,
    parameter int AXI_WIDTH  = 128,
    parameter int W_BPT      = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [ROWS*Y_BITS-1:0]   s_data,
    input  logic                     s_last,
    input  logic                     s_last_pkt,
    input  logic [W_BPT-1:0]         s_bytes_per_transfer,
    output logic [AXI_WIDTH-1:0]     m_tdata,
    output logic [AXI_WIDTH/8-1:0]   m_tkeep,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     m_tuser,
    output logic                     err_bpt,
    output logic [15:0]              pkt_count
);
    localparam int LANE_W = ROWS * Y_OUT_BITS;      // bits of one narrowed beat
    localparam int LB     = LANE_W / 8;             // bytes of one narrowed beat
    localparam int R      = AXI_WIDTH / LANE_W;     // beats per output word
    localparam int KW     = AXI_WIDTH / 8;
    localparam int LI_W   = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [0:0] {S_IDLE, S_OPEN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AXI_WIDTH-1:0]   r_acc;
    logic [LI_W-1:0]        r_lane;
    logic                   r_user_acc;
    logic [W_BPT-1:0]       r_byte_cnt;
    logic [W_BPT-1:0]       r_bpt_q;
    logic [AXI_WIDTH-1:0]   r_tdata;
    logic [KW-1:0]          r_tkeep;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic                   r_tuser;
    logic                   r_err;
    logic [15:0]            r_pkt_cnt;

    logic [LANE_W-1:0]      w_narrow;
    logic [AXI_WIDTH-1:0]   w_acc_new;
    logic [KW-1:0]          w_keep;
    logic                   w_accept;
    logic                   w_complete;
    logic [W_BPT-1:0]       w_bpt_exp;
    logic [W_BPT-1:0]       w_cnt_next;

    assign s_ready    = !r_tvalid || m_tready;
    assign w_accept   = s_valid && s_ready;
    assign w_complete = (r_lane == LI_W'(R - 1)) || s_last_pkt;
    assign w_cnt_next = r_byte_cnt + W_BPT'(LB);
    // On a packet's first beat bpt_q is not loaded yet, so a one-beat packet compares against the live input.
    assign w_bpt_exp  = (r_state == S_IDLE) ? s_bytes_per_transfer : r_bpt_q;

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        logic [Y_BITS-1:0]     w_in;
        logic [Y_OUT_BITS-1:0] w_out;
        assign w_in = s_data[g*Y_BITS +: Y_BITS];
`ifdef Y_SATURATE_EN
        // In range when every bit above the output sign bit is a copy of the input sign.
        always_comb begin
            if (w_in[Y_BITS-1:Y_OUT_BITS-1] == {(Y_BITS-Y_OUT_BITS+1){w_in[Y_BITS-1]}})
                w_out = w_in[Y_OUT_BITS-1:0];
            else if (w_in[Y_BITS-1])
                w_out = {1'b1, {(Y_OUT_BITS-1){1'b0}}};
            else
                w_out = {1'b0, {(Y_OUT_BITS-1){1'b1}}};
        end
`else
        logic w_unused_hi;
        assign w_out       = w_in[Y_OUT_BITS-1:0];
        assign w_unused_hi = ^w_in[Y_BITS-1:Y_OUT_BITS];
`endif
        assign w_narrow[g*Y_OUT_BITS +: Y_OUT_BITS] = w_out;
    end

    always_comb begin
        w_acc_new = r_acc;
        w_acc_new[r_lane*LANE_W +: LANE_W] = w_narrow;
    end

    always_comb begin
        w_keep = '0;
        for (int l = 0; l < R; l++) begin
            if (l <= int'(r_lane)) w_keep[l*LB +: LB] = '1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !s_last_pkt) w_state_nxt = S_OPEN;
            S_OPEN:  if (w_accept && s_last_pkt)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_acc      <= '0;
            r_lane     <= '0;
            r_user_acc <= 1'b0;
            r_byte_cnt <= '0;
            r_bpt_q    <= '0;
            r_err      <= 1'b0;
            r_pkt_cnt  <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) r_bpt_q <= s_bytes_per_transfer;
            if (w_complete) begin
                r_acc      <= '0;
                r_lane     <= '0;
                r_user_acc <= 1'b0;
            end else begin
                r_acc      <= w_acc_new;
                r_lane     <= r_lane + LI_W'(1);
                r_user_acc <= r_user_acc | s_last;
            end
            if (s_last_pkt) begin
                r_byte_cnt <= '0;
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                if (w_cnt_next != w_bpt_exp) r_err <= 1'b1;
            end else begin
                r_byte_cnt <= w_cnt_next;
            end
        end
    end

    // A load wins over the handshake drop, so a word can replace the departing one without a bubble.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_accept && w_complete) begin
            r_tdata  <= w_acc_new;
            r_tkeep  <= w_keep;
            r_tvalid <= 1'b1;
            r_tlast  <= s_last_pkt;
            r_tuser  <= r_user_acc | s_last;
        end else if (m_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_tdata   = r_tdata;
    assign m_tkeep   = r_tkeep;
    assign m_tvalid  = r_tvalid;
    assign m_tlast   = r_tlast;
    assign m_tuser   = r_tuser;
    assign err_bpt   = r_err;
    assign pkt_count = r_pkt_cnt;

endmodule

// File: tb/tb_axis_y_packer.sv
// Purpose : randomized and directed checks of axis_y_packer against a packet-level reference model.
// Latency : n/a (bench).
// Backpres: drives m_tready fixed, held low, or random per phase.
module tb_axis_y_packer;
    localparam int ROWS = 8, Y_BITS = 32, Y_OUT_BITS = 8, AXI_WIDTH = 128, W_BPT = 16;
    localparam int LB = 8, R = 2;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [255:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           s_last_pkt = 1'b0;
    logic [15:0]    s_bytes_per_transfer = '0;
    logic [127:0]   m_tdata;
    logic [15:0]    m_tkeep;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic           m_tlast;
    logic           m_tuser;
    logic           err_bpt;
    logic [15:0]    pkt_count;

    axis_y_packer #(
        .ROWS(ROWS), .Y_BITS(Y_BITS), .Y_OUT_BITS(Y_OUT_BITS), .AXI_WIDTH(AXI_WIDTH), .W_BPT(W_BPT)
    ) dut (
        .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_last_pkt(s_last_pkt), .s_bytes_per_transfer(s_bytes_per_transfer),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .err_bpt(err_bpt), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } word_t;

    word_t        exp_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    logic         exp_err = 1'b0;
    int           exp_pkt = 0;
    int           rdy_mode = 0;
    logic [127:0] last_word = '0;
    logic         held_vld = 1'b0;
    word_t        held;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] narrow(input logic [31:0] v);
`ifdef Y_SATURATE_EN
        int sv;
        sv = $signed(v);
        if (sv > 127)  return 8'h7F;
        if (sv < -128) return 8'h80;
        return v[7:0];
`else
        return v[7:0];
`endif
    endfunction

    function automatic logic [31:0] rand_row();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 255)) - 128;
            1:       v = int'($urandom_range(0, 400)) - 200;
            2:       v = int'($urandom_range(0, 100000)) - 50000;
            default: v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    // Monitor: compares each handshaken word and checks hold-stability while stalled.
    always @(negedge aclk) begin
        word_t e;
        if (areset) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                check("hold_tvalid", m_tvalid, 1);
                check("hold_tdata", m_tdata, held.data);
                check("hold_tkeep", m_tkeep, held.keep);
                check("hold_tlast_tuser", {m_tlast, m_tuser}, {held.last, held.user});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_tdata, e.data);
                    check("tkeep", m_tkeep, e.keep);
                    check("tlast", m_tlast, e.last);
                    check("tuser", m_tuser, e.user);
                    last_word = m_tdata;
                end
            end
            held_vld = m_tvalid && !m_tready;
            held     = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rdy_mode == 1) m_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Entered and left at posedge+1.
    task automatic drive_beat(input logic [255:0] d, input logic lst, input logic lp, input logic [15:0] bpt);
        int waited = 0;
        s_data = d; s_last = lst; s_last_pkt = lp; s_bytes_per_transfer = bpt; s_valid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_ready) break;
            waited++;
            if (waited > 300) begin
                check("beat_accept_timeout", s_ready, 1);
                break;
            end
            @(posedge aclk);
            #1;
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0; s_last = 1'b0; s_last_pkt = 1'b0;
    endtask

    task automatic send_packet(input int nb, input int bpt, input int gap_max,
                               input logic use_b0, input logic [255:0] b0);
        logic [255:0] d[$];
        logic         l[$];
        logic [255:0] bd;
        word_t        e;
        int           b;
        for (int i = 0; i < nb; i++) begin
            for (int r = 0; r < ROWS; r++) bd[r*32 +: 32] = rand_row();
            if (i == 0 && use_b0) bd = b0;
            d.push_back(bd);
            l.push_back($urandom_range(0, 3) == 0);
        end
        // Reference: beats grouped R per word, last word possibly partial.
        for (int w = 0; w * R < nb; w++) begin
            e = '0;
            for (int k = 0; k < R && w * R + k < nb; k++) begin
                b = w * R + k;
                for (int r = 0; r < ROWS; r++)
                    e.data[(k*ROWS + r)*8 +: 8] = narrow(d[b][r*32 +: 32]);
                e.keep[k*LB +: LB] = '1;
                e.user = e.user | l[b];
                if (b == nb - 1) e.last = 1'b1;
            end
            exp_q.push_back(e);
        end
        if (16'(nb * LB) != 16'(bpt)) exp_err = 1'b1;
        exp_pkt++;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge aclk);
                #1;
            end
            // Only the first beat's size is meaningful; later beats carry noise.
            drive_beat(d[i], l[i], i == nb - 1, (i == 0) ? 16'(bpt) : 16'($urandom));
        end
        check("err_bpt_after_close", err_bpt, exp_err);
        check("pkt_count", pkt_count, 16'(exp_pkt));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain_words_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [255:0] bd;
        int nb, bpt;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_ready", s_ready, 1);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tlast_tuser", {m_tlast, m_tuser}, 0);
        check("rst_err", err_bpt, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        send_packet(4, 32, 0, 1'b0, '0);   // full packet
        drain();
        send_packet(3, 24, 0, 1'b0, '0);   // odd-length flush
        drain();
        send_packet(2, 24, 0, 1'b0, '0);   // size mismatch
        drain();
        send_packet(2, 16, 1, 1'b0, '0);   // good packet, error stays sticky
        drain();

        // Backpressure: downstream stalled while four beats are offered.
        m_tready = 1'b0;
        fork
            send_packet(4, 32, 0, 1'b0, '0);
            begin
                repeat (5) @(negedge aclk);
                check("bp_s_ready", s_ready, 0);
                check("bp_tvalid", m_tvalid, 1);
                @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();

        // Narrowing of a positive and a negative out-of-range word.
        for (int r = 0; r < ROWS; r++) bd[r*32 +: 32] = rand_row();
        bd[31:0]  = 32'h0000_0123;
        bd[63:32] = 32'hFFFF_FF00;
        send_packet(2, 16, 0, 1'b1, bd);
        drain();
`ifdef Y_SATURATE_EN
        check("narrow_pos", last_word[7:0], 8'h7F);
        check("narrow_neg", last_word[15:8], 8'h80);
`else
        check("narrow_pos", last_word[7:0], 8'h23);
        check("narrow_neg", last_word[15:8], 8'h00);
`endif

        // Reset in the middle of a packet discards the partial word.
        for (int r = 0; r < ROWS; r++) bd[r*32 +: 32] = rand_row();
        drive_beat(bd, 1'b0, 1'b0, 16'd32);
        areset = 1'b1;
        exp_err = 1'b0;
        exp_pkt = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("rst_mid_no_word", m_tvalid, 0);
        end
        check("rst_mid_err", err_bpt, 0);
        check("rst_mid_pkt_count", pkt_count, 0);
        @(posedge aclk);
        #1;
        send_packet(2, 16, 0, 1'b0, '0);
        drain();

        // Randomized traffic with random downstream ready and input gaps.
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            nb  = $urandom_range(1, 7);
            bpt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 64)) : nb * LB;
            send_packet(nb, bpt, 2, 1'b0, '0);
        end
        rdy_mode = 0;
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        drain();
        check("final_err", err_bpt, exp_err);
        check("final_pkt_count", pkt_count, 16'(exp_pkt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
